credit_to_valrdy_mux: RTL

- Parametrised successor to the single-channel credit-to-val/rdy converter.
- Accepts NUM_CH independent credit-based input channels, each with its own DEPTH-entry buffer.
- Merges the channels onto one val/rdy output using round-robin arbitration and tags each output flit with its source channel.
- Returns one credit per channel on yummy_in when that channel's entry leaves, and flags any sender that overruns its credits.

---
 rtl/credit_to_valrdy_mux.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/credit_to_valrdy_mux.sv
// Purpose: merges NUM_CH credit-based input channels, each with a DEPTH-entry buffer, onto one val/rdy output.
// Latency: 1 cycle from valid_in to valid_out (no bypass); yummy_in pulses 1 cycle after each transfer.
// Backpressure: ready_out=0 freezes the grant, data_out and chan_out; senders are throttled by credits only.
//
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   data_in       - NUM_CH flits, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   valid_in      - per-channel flit valid (sender must hold a credit)
//   yummy_in      - per-channel credit return, one pulse per freed entry
//   data_out      - head flit of the granted channel
//   valid_out     - at least one buffered flit is presented
//   ready_out     - consumer accepts data_out this cycle
//   chan_out      - source channel of data_out
//   overflow_err  - sticky per-channel flag: sender wrote into a full buffer
module credit_to_valrdy_mux #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_CH = 2,
    parameter int DEPTH = 4,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_CH-1:0]            valid_in,
    output logic [NUM_CH-1:0]            yummy_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic [CH_W-1:0]              chan_out,
    output logic [NUM_CH-1:0]            overflow_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0]  CH_ONE   = CH_W'(1);

    logic [NUM_CH-1:0]     nonempty;
    logic [NUM_CH-1:0]     full;
    logic [NUM_CH-1:0]     push;
    logic [NUM_CH-1:0]     pop;
    logic [NUM_CH-1:0]     drop;
    logic [DATA_WIDTH-1:0] head [NUM_CH];

    logic [CH_W-1:0]       rr_start;
    logic [CH_W-1:0]       rr_pick;
    logic [CH_W-1:0]       grant;
    logic [CH_W-1:0]       hold_ch;
    logic                  hold_vld;
    logic                  xfer;
    logic [NUM_CH-1:0]     yummy_q;

    // Per-channel circular buffer.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [PTR_W-1:0]      rd_ptr;
        logic [PTR_W-1:0]      wr_ptr;
        logic [CNT_W-1:0]      count;

        assign nonempty[i] = (count != '0);
        assign full[i]     = (count == CNT_FULL);
        assign head[i]     = mem[rd_ptr];
        // A full buffer still takes a flit when its head leaves on the same edge.
        assign push[i]     = valid_in[i] && (!full[i] || pop[i]);
        assign drop[i]     = valid_in[i] && full[i] && !pop[i];

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                // Explicit wrap keeps non-power-of-2 depths correct.
                if (push[i]) begin
                    wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
                end
                if (pop[i]) begin
                    rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
                end
                case ({push[i], pop[i]})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end

        // Storage is not reset; it is only observed through the count.
        always_ff @(posedge clk) begin
            if (push[i] && !reset) begin
                mem[wr_ptr] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        logic found;
        int   idx;
        rr_pick = rr_start;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_start) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && nonempty[idx]) begin
                rr_pick = CH_W'(idx);
                found   = 1'b1;
            end
        end
    end

    // A stalled grant is frozen so a newly filled channel cannot preempt it;
    // the held channel cannot drain while stalled, so it stays non-empty.
    assign grant     = hold_vld ? hold_ch : rr_pick;
    // Outputs are masked while reset is high so nothing is presented or credited.
    assign valid_out = (|nonempty) && !reset;
    assign xfer      = valid_out && ready_out;
    assign data_out  = valid_out ? head[grant] : '0;
    assign chan_out  = valid_out ? grant : '0;
    assign yummy_in  = yummy_q & {NUM_CH{~reset}};

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop[i] = xfer && (grant == CH_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_start     <= '0;
            hold_vld     <= 1'b0;
            hold_ch      <= '0;
            yummy_q      <= '0;
            overflow_err <= '0;
        end else begin
            yummy_q      <= pop;
            overflow_err <= overflow_err | drop;
            hold_vld     <= valid_out && !ready_out;
            hold_ch      <= grant;
            if (xfer) begin
                rr_start <= (grant == CH_LAST) ? '0 : grant + CH_ONE;
            end
        end
    end

endmodule
